// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle program-counter controller for the MIPS datapath. It owns the
// PC and walks every instruction through FETCH -> ISSUE -> RESOLVE. It
// fetches over a req/ack handshake, hands the instruction to the control
// unit, and then selects the next PC (jr > jump > branch > sequential).
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   fetch_req/addr/ack/data  instruction memory handshake, addr == pc
//   instr_valid/out/accept   instruction handoff to the control unit
//   resolve_valid, branch_taken, branch_offset, jump, jump_index,
//   jr, jr_target, halt      control-flow outcome, sampled in RESOLVE only
//   pc                    current program counter
//   exc_misalign          sticky: a jr target had non-zero low bits
//   fetch_err             sticky: memory did not ack within TIMEOUT cycles
//   retired               count of resolved instructions (wraps)
//   halted                controller is parked in HALT until reset
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    input  logic        instr_accept,
    input  logic        resolve_valid,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        exc_misalign,
    output logic        fetch_err,
    output logic [15:0] retired,
    output logic        halted
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RESOLVE,
        HALT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] tcount;
    logic          timeout_hit;
    logic          misalign;
    logic [31:0]   pc4;
    logic [31:0]   branch_disp;
    logic [31:0]   next_pc;

    assign fetch_addr  = pc;
    assign timeout_hit = (tcount == TLIMIT) && !fetch_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; each state only looks at the inputs it owns, so
    // handshake signals arriving in other states are ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH: begin
                if (fetch_ack) begin
                    next_state = ISSUE;
                end else if (timeout_hit) begin
                    next_state = HALT;
                end
            end
            ISSUE: begin
                if (instr_accept) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                if (resolve_valid) begin
                    next_state = halt ? HALT : FETCH;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state.
    always_comb begin
        fetch_req   = (state == FETCH);
        instr_valid = (state == ISSUE);
        halted      = (state == HALT);
    end

    // Next-PC selection. Branch offsets and jump indices are word counts,
    // hence the shift by two; the jump keeps the top nibble of pc+4.
    always_comb begin
        pc4         = pc + 32'd4;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        misalign    = jr && (jr_target[1:0] != 2'b00);
        next_pc     = pc4;
        if (jr) begin
            next_pc = misalign ? EXC_VECTOR : jr_target;
        end else if (jump) begin
            next_pc = {pc4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc4 + branch_disp;
        end
    end

    // Datapath registers. The timeout counter is held at zero outside
    // FETCH, which gives the clear-on-entry behaviour for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            instr_out    <= 32'h0;
            exc_misalign <= 1'b0;
            fetch_err    <= 1'b0;
            retired      <= 16'h0;
            tcount       <= '0;
        end else begin
            if (state == FETCH) begin
                if (fetch_ack) begin
                    instr_out <= fetch_data;
                end else if (timeout_hit) begin
                    fetch_err <= 1'b1;
                end else begin
                    tcount <= tcount + 1'b1;
                end
            end else begin
                tcount <= '0;
            end
            if (state == RESOLVE && resolve_valid) begin
                pc      <= next_pc;
                retired <= retired + 16'd1;
                if (misalign) begin
                    exc_misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed testbench for pc_sequencer: each scenario task drives the
// handshakes and compares the outputs against hand-computed values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        instr_accept;
    logic        resolve_valid;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc;
    logic        exc_misalign;
    logic        fetch_err;
    logic [15:0] retired;
    logic        halted;

    int          checks;
    int          errors;
    logic [31:0] last_addr;
    logic [31:0] last_instr;
    logic [15:0] exp_retired;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .fetch_data   (fetch_data),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .instr_accept (instr_accept),
        .resolve_valid(resolve_valid),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .halt         (halt),
        .pc           (pc),
        .exc_misalign (exc_misalign),
        .fetch_err    (fetch_err),
        .retired      (retired),
        .halted       (halted)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_ack     = 1'b0;
        fetch_data    = 32'h0;
        instr_accept  = 1'b0;
        resolve_valid = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jr            = 1'b0;
        jr_target     = 32'h0;
        halt          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset       = 1'b0;
        exp_retired = 16'h0;
    endtask

    task automatic wait_fetch();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fetch_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_fetch: fetch_req=%b required 1 within 40 cycles", fetch_req);
        end
    endtask

    // Runs one instruction with immediate ack/accept/resolve, applying the
    // given control-flow outcome at resolve.
    task automatic run_instr(input logic [31:0] data, input logic br,
                             input logic [15:0] off, input logic jmp,
                             input logic [25:0] idx, input logic jrr,
                             input logic [31:0] jt, input logic hlt);
        bit seen;
        wait_fetch();
        last_addr  = fetch_addr;
        fetch_ack  = 1'b1;
        fetch_data = data;
        step();
        fetch_ack  = 1'b0;
        fetch_data = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_issue: instr_valid=%b required 1 within 20 cycles", instr_valid);
        end
        last_instr   = instr_out;
        instr_accept = 1'b1;
        step();
        instr_accept  = 1'b0;
        resolve_valid = 1'b1;
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_index    = idx;
        jr            = jrr;
        jr_target     = jt;
        halt          = hlt;
        step();
        clear_inputs();
        exp_retired = exp_retired + 16'd1;
    endtask

    task automatic run_seq(input logic [31:0] data);
        run_instr(data, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic run_jr(input logic [31:0] target);
        run_instr(32'h0300_0008, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, target, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h0 || fetch_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pc: pc=%h fetch_addr=%h required 00000000", pc, fetch_addr);
        end
        checks++;
        if ({fetch_req, instr_valid, exc_misalign, fetch_err, halted} !== 5'b0 ||
            retired !== 16'h0 || instr_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: req=%b vld=%b exc=%b err=%b halted=%b retired=%h instr=%h required all 0",
                     fetch_req, instr_valid, exc_misalign, fetch_err, halted, retired, instr_out);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3];
        logic [31:0] data     [3];
        exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
        data[0] = 32'h2008_0001; data[1] = 32'hDEAD_BEEF; data[2] = 32'h0123_4567;
        for (int i = 0; i < 3; i++) begin
            run_seq(data[i]);
            checks++;
            if (last_addr !== exp_addr[i]) begin
                errors++;
                $display("[TB] FAIL seq_addr[%0d]: fetch_addr=%h required %h", i, last_addr, exp_addr[i]);
            end
            checks++;
            if (last_instr !== data[i]) begin
                errors++;
                $display("[TB] FAIL seq_instr[%0d]: instr_out=%h required %h", i, last_instr, data[i]);
            end
        end
        checks++;
        if (retired !== 16'd3 || pc !== 32'hC) begin
            errors++;
            $display("[TB] FAIL seq_end: retired=%0d pc=%h required 3 0000000c", retired, pc);
        end
    endtask

    task automatic test_branch();
        run_seq(32'h0);
        run_instr(32'h1000_FFFC, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (last_addr !== 32'h10 || pc !== 32'h4) begin
            errors++;
            $display("[TB] FAIL branch_back: from=%h pc=%h required from 00000010 pc 00000004", last_addr, pc);
        end
        run_jr(32'h10);
        run_instr(32'h1000_0003, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (last_addr !== 32'h10 || pc !== 32'h20) begin
            errors++;
            $display("[TB] FAIL branch_fwd: from=%h pc=%h required from 00000010 pc 00000020", last_addr, pc);
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("[TB] FAIL branch_retired: retired=%0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_jump();
        run_jr(32'h1000_0000);
        run_instr(32'h0800_0040, 1'b0, 16'h0, 1'b1, 26'h0000040, 1'b0, 32'h0, 1'b0);
        checks++;
        if (pc !== 32'h1000_0100) begin
            errors++;
            $display("[TB] FAIL jump: pc=%h required 10000100", pc);
        end
        run_instr(32'h0, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b1, 32'h0000_0400, 1'b0);
        checks++;
        if (pc !== 32'h0000_0400) begin
            errors++;
            $display("[TB] FAIL jr_priority: pc=%h required 00000400", pc);
        end
        // jump beats branch: pc4=0x404 keeps top nibble 0, index 0x10 -> 0x40
        run_instr(32'h0, 1'b1, 16'h0005, 1'b1, 26'h0000010, 1'b0, 32'h0, 1'b0);
        checks++;
        if (pc !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL jump_priority: pc=%h required 00000040", pc);
        end
    endtask

    task automatic test_misalign();
        checks++;
        if (exc_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_pre: exc_misalign=%b required 0", exc_misalign);
        end
        run_jr(32'h0000_0402);
        checks++;
        if (pc !== 32'h0000_0080 || exc_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign: pc=%h exc=%b required 00000080 1", pc, exc_misalign);
        end
        run_seq(32'h0);
        checks++;
        if (pc !== 32'h0000_0084 || exc_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_sticky: pc=%h exc=%b required 00000084 1", pc, exc_misalign);
        end
    endtask

    task automatic test_wrap();
        run_jr(32'hFFFF_FFFC);
        run_seq(32'h0);
        checks++;
        if (last_addr !== 32'hFFFF_FFFC || pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL pc_wrap: from=%h pc=%h required from fffffffc pc 00000000", last_addr, pc);
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("[TB] FAIL wrap_retired: retired=%0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_reset_mid_issue();
        wait_fetch();
        fetch_ack  = 1'b1;
        fetch_data = 32'hCAFE_F00D;
        step();
        fetch_ack  = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_issue_setup: instr_valid=%b required 1", instr_valid);
        end
        reset = 1'b1;
        step();
        reset       = 1'b0;
        exp_retired = 16'h0;
        checks++;
        if (pc !== 32'h0 || instr_out !== 32'h0 || retired !== 16'h0 ||
            {fetch_req, instr_valid, exc_misalign, fetch_err, halted} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mid_issue_reset: pc=%h instr=%h retired=%h req=%b vld=%b exc=%b err=%b halted=%b required all 0",
                     pc, instr_out, retired, fetch_req, instr_valid, exc_misalign, fetch_err, halted);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        wait_fetch();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (fetch_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_cycle16: req=%b err=%b required 1 0", fetch_req, fetch_err);
        end
        step();
        checks++;
        if (fetch_err !== 1'b1 || halted !== 1'b1 || fetch_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout: err=%b halted=%b req=%b required 1 1 0", fetch_err, halted, fetch_req);
        end
    endtask

    task automatic test_ack_cycle15();
        do_reset();
        wait_fetch();
        for (int i = 0; i < 14; i++) step();
        fetch_ack  = 1'b1;
        fetch_data = 32'h1234_5678;
        step();
        fetch_ack  = 1'b0;
        checks++;
        if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr_out !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL ack15: err=%b vld=%b instr=%h required 0 1 12345678", fetch_err, instr_valid, instr_out);
        end
        instr_accept = 1'b1;
        step();
        instr_accept  = 1'b0;
        resolve_valid = 1'b1;
        step();
        clear_inputs();
        exp_retired = 16'd1;
        checks++;
        if (pc !== 32'h4 || retired !== 16'd1) begin
            errors++;
            $display("[TB] FAIL ack15_resolve: pc=%h retired=%0d required 00000004 1", pc, retired);
        end
    endtask

    task automatic test_halt();
        run_instr(32'h0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (halted !== 1'b1 || pc !== 32'h8) begin
            errors++;
            $display("[TB] FAIL halt: halted=%b pc=%h required 1 00000008", halted, pc);
        end
        // All handshakes asserted while halted must be ignored.
        fetch_ack     = 1'b1;
        instr_accept  = 1'b1;
        resolve_valid = 1'b1;
        jr            = 1'b1;
        jr_target     = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h8 || retired !== exp_retired) begin
                errors++;
                $display("[TB] FAIL halt_hold[%0d]: req=%b vld=%b pc=%h retired=%0d required 0 0 00000008 %0d",
                         i, fetch_req, instr_valid, pc, retired, exp_retired);
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_retired = 16'h0;
        reset       = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_misalign();
        test_wrap();
        test_reset_mid_issue();
        test_timeout();
        test_ack_cycle15();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
